// File: rtl/jtag_uart_0_dsink_pkg.sv
`default_nettype none
// ============================================================================
// jtag_uart_0_dsink_pkg : shared types for the JTAG UART transmit sink
// Rev 1.0
// ============================================================================
package jtag_uart_0_dsink_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESENT = 2'd1,
    ST_PACE    = 2'd2,
    ST_FLUSH   = 2'd3
  } state_t;

  typedef logic [7:0] byte_t;

  localparam logic [31:0] NUM_BYTES_MAX = 32'hFFFF_FFFF;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == NUM_BYTES_MAX) ? v : v + 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/jtag_uart_0_dsink_fifo.sv
`default_nettype none
// ============================================================================
// jtag_uart_0_dsink_fifo : DEPTH x 8 synchronous FIFO, head visible on rd_data
// Rev 1.0
// ============================================================================
module jtag_uart_0_dsink_fifo
  import jtag_uart_0_dsink_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  byte_t             wr_data,
  input  logic              pop,
  output byte_t             rd_data,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  byte_t             mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              push_ok, pop_ok;

  assign full    = (count_q == DEPTH_C);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  // A write while full is dropped even if a pop frees a slot this cycle.
  assign push_ok = wr_en && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    wr_ptr_d = push_ok ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (ADDR_W+1)'(1);
      2'b01:   count_d = count_q - (ADDR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule
`default_nettype wire

// File: rtl/jtag_uart_0_dsink_module.sv
`default_nettype none
// ============================================================================
// jtag_uart_0_dsink_module : buffers CPU-written bytes, drains them paced,
// counts them and pulses flush once the stream has gone idle. Rev 1.0
// ============================================================================
module jtag_uart_0_dsink_module
  import jtag_uart_0_dsink_pkg::*;
#(
  parameter int DEPTH      = 64,
  parameter int ADDR_W     = 6,
  parameter int POLL_RATE  = 100,
  parameter int IDLE_FLUSH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  output logic              wr_full,
  output logic [ADDR_W:0]   wr_avail,
  output logic              overflow,
  output logic              out_valid,
  output logic [7:0]        out_data,
  input  logic              out_ready,
  output logic              flush,
  output logic [31:0]       num_bytes
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam int PACE_W = (POLL_RATE > 1) ? $clog2(POLL_RATE) : 1;
  localparam int IDLE_W = (IDLE_FLUSH > 1) ? $clog2(IDLE_FLUSH) : 1;
  localparam logic [PACE_W-1:0] PACE_LAST = PACE_W'((POLL_RATE > 0) ? POLL_RATE - 1 : 0);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_FLUSH - 1);

  state_t              state_q, state_d;
  logic                out_valid_q, out_valid_d;
  byte_t               out_data_q, out_data_d;
  logic [PACE_W-1:0]   pace_cnt_q, pace_cnt_d;
  logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;
  logic                dirty_q, dirty_d;
  logic [31:0]         num_bytes_q, num_bytes_d;
  logic                overflow_q, overflow_d;

  logic                fifo_pop, fifo_full, fifo_empty, wr_accept;
  byte_t               fifo_head;
  logic [ADDR_W:0]     fifo_count;

  jtag_uart_0_dsink_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .pop     (fifo_pop),
    .rd_data (fifo_head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign wr_accept = wr_en && !fifo_full;

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    pace_cnt_d  = pace_cnt_q;
    idle_cnt_d  = idle_cnt_q;
    dirty_d     = dirty_q;
    num_bytes_d = num_bytes_q;
    fifo_pop    = 1'b0;
    overflow_d  = overflow_q | (wr_en & fifo_full);

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          state_d     = ST_PRESENT;
          out_valid_d = 1'b1;
          out_data_d  = fifo_head;
          idle_cnt_d  = '0;
        end else if (dirty_q && (idle_cnt_q == IDLE_LAST) && !wr_accept) begin
          // A write landing now would make the FIFO non-empty during the pulse.
          state_d    = ST_FLUSH;
          idle_cnt_d = '0;
        end else if (idle_cnt_q != IDLE_LAST) begin
          idle_cnt_d = idle_cnt_q + IDLE_W'(1);
        end
      end
      ST_PRESENT: begin
        if (out_ready) begin
          fifo_pop    = 1'b1;
          out_valid_d = 1'b0;
          num_bytes_d = sat_inc32(num_bytes_q);
          dirty_d     = 1'b1;
          pace_cnt_d  = '0;
          state_d     = (POLL_RATE == 0) ? ST_IDLE : ST_PACE;
        end
      end
      ST_PACE: begin
        pace_cnt_d = pace_cnt_q + PACE_W'(1);
        if (pace_cnt_q == PACE_LAST) state_d = ST_IDLE;
      end
      ST_FLUSH: begin
        dirty_d = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (wr_accept) idle_cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      pace_cnt_q  <= '0;
      idle_cnt_q  <= '0;
      dirty_q     <= 1'b0;
      num_bytes_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      pace_cnt_q  <= pace_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      dirty_q     <= dirty_d;
      num_bytes_q <= num_bytes_d;
      overflow_q  <= overflow_d;
    end
  end

  assign wr_full   = fifo_full;
  assign wr_avail  = DEPTH_C - fifo_count;
  assign overflow  = overflow_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign flush     = (state_q == ST_FLUSH);
  assign num_bytes = num_bytes_q;

endmodule
`default_nettype wire

// File: tb/tb_jtag_uart_0_dsink_module.sv
`default_nettype none
// ============================================================================
// tb_jtag_uart_0_dsink_module : directed scoreboard bench, two pacing configs
// Rev 1.0
// ============================================================================
module tb_jtag_uart_0_dsink_module;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_data = 8'h00;
  logic        out_ready = 1'b0;

  logic        d0_wr_full, d0_overflow, d0_out_valid, d0_flush;
  logic [6:0]  d0_wr_avail;
  logic [7:0]  d0_out_data;
  logic [31:0] d0_num_bytes;
  logic        d3_wr_full, d3_overflow, d3_out_valid, d3_flush;
  logic [6:0]  d3_wr_avail;
  logic [7:0]  d3_out_data;
  logic [31:0] d3_num_bytes;

  always #5 clk = ~clk;

  jtag_uart_0_dsink_module #(.DEPTH(64), .ADDR_W(6), .POLL_RATE(0), .IDLE_FLUSH(16)) dut0 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .wr_full(d0_wr_full), .wr_avail(d0_wr_avail), .overflow(d0_overflow),
    .out_valid(d0_out_valid), .out_data(d0_out_data), .out_ready(out_ready),
    .flush(d0_flush), .num_bytes(d0_num_bytes));

  jtag_uart_0_dsink_module #(.DEPTH(64), .ADDR_W(6), .POLL_RATE(3), .IDLE_FLUSH(16)) dut3 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .wr_full(d3_wr_full), .wr_avail(d3_wr_avail), .overflow(d3_overflow),
    .out_valid(d3_out_valid), .out_data(d3_out_data), .out_ready(out_ready),
    .flush(d3_flush), .num_bytes(d3_num_bytes));

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          flush_cnt = 0;
  int          last_xfer_cyc = 0;
  int          last_flush_cyc = 0;
  logic [7:0]  sb[$];
  int          t3_cyc[$];
  logic [7:0]  t3_dat[$];
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_data = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Observes outputs mid-cycle: scoreboard pops, stall stability, flush safety.
  task automatic monitor();
    logic [31:0] exp;
    if (!reset) begin
      if (prev_stall) begin
        check("stall_valid", {31'd0, d0_out_valid}, 32'd1);
        check("stall_data", {24'd0, d0_out_data}, {24'd0, prev_data});
      end
      if (d0_out_valid && out_ready) begin
        exp = (sb.size() > 0) ? {24'd0, sb.pop_front()} : 32'h1FF;
        check("xfer_data", {24'd0, d0_out_data}, exp);
        last_xfer_cyc = cyc;
      end
      if (d0_flush) begin
        flush_cnt++;
        last_flush_cyc = cyc;
        check("flush_valid_low", {31'd0, d0_out_valid}, 32'd0);
        check("flush_fifo_empty", {25'd0, d0_wr_avail}, 32'd64);
      end
      if (d3_out_valid && out_ready) begin
        t3_cyc.push_back(cyc);
        t3_dat.push_back(d3_out_data);
      end
    end
    prev_stall = !reset && d0_out_valid && !out_ready;
    prev_data  = d0_out_data;
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wr(input logic [7:0] b, input bit accept);
    wr_en   = 1'b1;
    wr_data = b;
    if (accept) sb.push_back(b);
    step();
    wr_en = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    wr_en = 1'b0;
    sb.delete();
    step();
    reset = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_valid"},   {31'd0, d0_out_valid}, 32'd0);
    check({tag, "_data"},    {24'd0, d0_out_data},  32'd0);
    check({tag, "_full"},    {31'd0, d0_wr_full},   32'd0);
    check({tag, "_avail"},   {25'd0, d0_wr_avail},  32'd64);
    check({tag, "_ovf"},     {31'd0, d0_overflow},  32'd0);
    check({tag, "_flush"},   {31'd0, d0_flush},     32'd0);
    check({tag, "_nbytes"},  d0_num_bytes,          32'd0);
  endtask

  initial begin
    int fb;
    int d;
    // ---- 1: single byte, latency, single flush ----
    step();
    do_reset();
    check_reset_state("rst0");
    out_ready = 1'b1;
    fb = flush_cnt;
    wr(8'h41, 1'b1);
    check("lat_n1_valid", {31'd0, d0_out_valid}, 32'd0);
    step();
    check("lat_n2_valid", {31'd0, d0_out_valid}, 32'd1);
    check("lat_n2_data", {24'd0, d0_out_data}, 32'h41);
    repeat (40) step();
    check("t1_nbytes", d0_num_bytes, 32'd1);
    check("t1_flush_once", flush_cnt - fb, 32'd1);
    d = last_flush_cyc - last_xfer_cyc;
    check("t1_flush_delay", {31'd0, (d >= 16 && d <= 17)}, 32'd1);
    check("t1_sb_empty", sb.size(), 32'd0);

    // ---- 2: fill, overflow, drain in order ----
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 64; i++) wr(8'(i), 1'b1);
    check("t2_full", {31'd0, d0_wr_full}, 32'd1);
    check("t2_avail", {25'd0, d0_wr_avail}, 32'd0);
    check("t2_ovf_pre", {31'd0, d0_overflow}, 32'd0);
    wr(8'hAA, 1'b0);
    check("t2_ovf_set", {31'd0, d0_overflow}, 32'd1);
    out_ready = 1'b1;
    repeat (150) step();
    check("t2_nbytes", d0_num_bytes, 32'd64);
    check("t2_sb_empty", sb.size(), 32'd0);
    check("t2_ovf_sticky", {31'd0, d0_overflow}, 32'd1);

    // ---- 6: write while full coincident with a transfer ----
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 64; i++) wr(8'h80 + 8'(i), 1'b1);
    wr_en = 1'b1;
    wr_data = 8'hEE;
    out_ready = 1'b1;
    step();
    wr_en = 1'b0;
    out_ready = 1'b0;
    check("t6_ovf", {31'd0, d0_overflow}, 32'd1);
    check("t6_avail", {25'd0, d0_wr_avail}, 32'd1);
    check("t6_full", {31'd0, d0_wr_full}, 32'd0);
    out_ready = 1'b1;
    repeat (150) step();
    check("t6_sb_empty", sb.size(), 32'd0);
    check("t6_nbytes", d0_num_bytes, 32'd64);

    // ---- 3: paced drain, POLL_RATE=3 ----
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) wr(8'hC0 + 8'(i), 1'b1);
    t3_cyc.delete();
    t3_dat.delete();
    out_ready = 1'b1;
    repeat (40) step();
    check("t3_count", t3_cyc.size(), 32'd4);
    if (t3_cyc.size() == 4) begin
      for (int i = 0; i < 4; i++) check("t3_data", {24'd0, t3_dat[i]}, 32'hC0 + 32'(i));
      for (int i = 1; i < 4; i++) check("t3_spacing", t3_cyc[i] - t3_cyc[i-1], 32'd5);
    end
    check("t3_d3_nbytes", d3_num_bytes, 32'd4);

    // ---- 4: random backpressure ----
    do_reset();
    for (int i = 0; i < 10; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      wr(8'h50 + 8'(i), 1'b1);
    end
    for (int i = 0; i < 60; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      step();
    end
    out_ready = 1'b1;
    repeat (20) step();
    check("t4_sb_empty", sb.size(), 32'd0);
    check("t4_nbytes", d0_num_bytes, 32'd10);

    // ---- 5: reset while presenting ----
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) wr(8'h10 + 8'(i), 1'b1);
    for (int i = 0; i < 10 && !d0_out_valid; i++) step();
    check("t5_valid_before", {31'd0, d0_out_valid}, 32'd1);
    do_reset();
    check_reset_state("rst5");
    out_ready = 1'b1;
    wr(8'h7E, 1'b1);
    repeat (30) step();
    check("t5_sb_empty", sb.size(), 32'd0);
    check("t5_nbytes", d0_num_bytes, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
